// File: rtl/select_encode_sched.sv
// Registered register select/encode: latches IR, decodes ra/rb/rc into one-hot
// register enables, and keeps a per-register write-pending scoreboard for stalls.
module select_encode_sched #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_ID_W = 4,
  parameter int OP_MSB   = 31,
  parameter int RA_MSB   = 26,
  parameter int RB_MSB   = 22,
  parameter int RC_MSB   = 18,
  parameter int IMM_W    = 19
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                ir_load,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  input  logic                wb_issue,
  input  logic                wb_done,
  input  logic [REG_ID_W-1:0] wb_done_id,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                ba_zero,
  output logic [REG_ID_W-1:0] sel_id,
  output logic [4:0]          opcode,
  output logic [DATA_W-1:0]   c_sign_extended,
  output logic [NUM_REGS-1:0] pending,
  output logic                stall
);

  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [NUM_REGS-1:0] r_in_q, r_in_d;
  logic [NUM_REGS-1:0] r_out_q, r_out_d;
  logic                ba_zero_q, ba_zero_d;
  logic [REG_ID_W-1:0] sel_id_q;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  logic [REG_ID_W-1:0] idx;
  logic                sel_any;
  logic                rd_req;
  logic                ba_reg0;
  logic [NUM_REGS-1:0] onehot;

  // Fixed priority gra > grb > grc; with nothing selected idx falls to 0.
  always_comb begin
    idx = '0;
    if (gra)      idx = ir_q[RA_MSB -: REG_ID_W];
    else if (grb) idx = ir_q[RB_MSB -: REG_ID_W];
    else if (grc) idx = ir_q[RC_MSB -: REG_ID_W];
  end

  assign sel_any = gra | grb | grc;
  assign rd_req  = (rout | baout) & sel_any;
  assign ba_reg0 = baout & sel_any & (idx == '0);
  assign onehot  = NUM_REGS'(1) << idx;

  always_comb begin
    ir_d      = ir_load ? ir_in : ir_q;
    r_in_d    = (rin & sel_any) ? onehot : '0;
    // Base-address read of r0 gates the register off; the bus drives zero instead.
    r_out_d   = (rd_req & ~ba_reg0) ? onehot : '0;
    ba_zero_d = ba_reg0;
    // Clear before set so an issue and a completion on the same register leaves it pending.
    pending_d = pending_q;
    if (wb_done)  pending_d[wb_done_id] = 1'b0;
    if (wb_issue) pending_d[idx]        = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ir_q      <= '0;
      r_in_q    <= '0;
      r_out_q   <= '0;
      ba_zero_q <= 1'b0;
      sel_id_q  <= '0;
      pending_q <= '0;
    end else begin
      ir_q      <= ir_d;
      r_in_q    <= r_in_d;
      r_out_q   <= r_out_d;
      ba_zero_q <= ba_zero_d;
      sel_id_q  <= idx;
      pending_q <= pending_d;
    end
  end

  assign r_in            = r_in_q;
  assign r_out           = r_out_q;
  assign ba_zero         = ba_zero_q;
  assign sel_id          = sel_id_q;
  assign pending         = pending_q;
  assign opcode          = ir_q[OP_MSB -: 5];
  assign c_sign_extended = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign stall           = rd_req & pending_q[idx] & ~ba_reg0;

endmodule

// File: tb/tb_select_encode_sched.sv
// Directed bench for select_encode_sched: decode, priority, sign extension,
// base-address zero, scoreboard set/clear/stall and mid-run reset.
module tb_select_encode_sched;

  logic        clk = 1'b0;
  logic        clr, ir_load, gra, grb, grc, rin, rout, baout;
  logic        wb_issue, wb_done;
  logic [3:0]  wb_done_id;
  logic [31:0] ir_in;
  logic [15:0] r_in, r_out, pending;
  logic        ba_zero, stall;
  logic [3:0]  sel_id;
  logic [4:0]  opcode;
  logic [31:0] c_sign_extended;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  select_encode_sched dut (
    .clk(clk), .clr(clr), .ir_in(ir_in), .ir_load(ir_load),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .wb_issue(wb_issue), .wb_done(wb_done), .wb_done_id(wb_done_id),
    .r_in(r_in), .r_out(r_out), .ba_zero(ba_zero), .sel_id(sel_id),
    .opcode(opcode), .c_sign_extended(c_sign_extended),
    .pending(pending), .stall(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    {ir_load, gra, grb, grc, rin, rout, baout, wb_issue, wb_done} = '0;
    wb_done_id = '0;
  endtask

  task automatic load(input logic [31:0] w);
    idle();
    ir_in = w; ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
  endtask

  initial begin
    idle();
    ir_in = '0;
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    chk("rst_r_in", 32'(r_in), 32'h0);
    chk("rst_r_out", 32'(r_out), 32'h0);
    chk("rst_ba_zero", 32'(ba_zero), 32'h0);
    chk("rst_sel_id", 32'(sel_id), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_c", c_sign_extended, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // opcode=3 ra=1 rb=2 rc=3 C=0x18000
    load(32'h18918000);
    chk("ld_opcode", 32'(opcode), 32'd3);
    chk("ld_c", c_sign_extended, 32'h00018000);

    gra = 1'b1; grb = 1'b1; rin = 1'b1;
    tick();
    idle();
    chk("prio_r_in", 32'(r_in), 32'h0002);
    chk("prio_r_out", 32'(r_out), 32'h0);
    chk("prio_sel_id", 32'(sel_id), 32'd1);

    load(32'h0007FFFF);
    chk("sext_all1", c_sign_extended, 32'hFFFFFFFF);
    chk("sext_op0", 32'(opcode), 32'd0);
    load(32'h00040000);
    chk("sext_msb", c_sign_extended, 32'hFFFC0000);

    // rb=0 with baout: register gated, bus zero
    grb = 1'b1; baout = 1'b1;
    tick();
    idle();
    chk("ba0_r_out", 32'(r_out), 32'h0);
    chk("ba0_ba_zero", 32'(ba_zero), 32'h1);

    load(32'h00280000);  // rb=5
    grb = 1'b1; baout = 1'b1;
    tick();
    idle();
    chk("ba5_r_out", 32'(r_out), 32'h0020);
    chk("ba5_ba_zero", 32'(ba_zero), 32'h0);
    chk("ba5_sel_id", 32'(sel_id), 32'd5);

    load(32'h18918000);
    grc = 1'b1; wb_issue = 1'b1;
    tick();
    idle();
    chk("sb_set", 32'(pending), 32'h0008);
    chk("sb_sel_id", 32'(sel_id), 32'd3);

    grc = 1'b1; rout = 1'b1;
    #1;
    chk("sb_stall", 32'(stall), 32'h1);
    tick();
    chk("sb_r_out_nosup", 32'(r_out), 32'h0008);

    wb_done = 1'b1; wb_done_id = 4'd3;
    tick();
    wb_done = 1'b0;
    chk("sb_clear", 32'(pending), 32'h0);
    chk("sb_unstall", 32'(stall), 32'h0);
    idle();

    grc = 1'b1; wb_issue = 1'b1; wb_done = 1'b1; wb_done_id = 4'd3;
    tick();
    idle();
    chk("sb_set_wins", 32'(pending), 32'h0008);

    wb_issue = 1'b1;  // no gr*: targets r0
    tick();
    idle();
    chk("sb_nogr_r0", 32'(pending), 32'h0009);

    rout = 1'b1;  // no gr*: not a read request
    #1;
    chk("nogr_nostall", 32'(stall), 32'h0);
    idle();

    grc = 1'b1; rin = 1'b1;
    tick();
    chk("pre_clr_r_in", 32'(r_in), 32'h0008);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle();
    #1;
    chk("clr_r_in", 32'(r_in), 32'h0);
    chk("clr_pending", 32'(pending), 32'h0);
    chk("clr_sel_id", 32'(sel_id), 32'h0);
    chk("clr_opcode", 32'(opcode), 32'h0);
    chk("clr_c", c_sign_extended, 32'h0);
    chk("clr_stall", 32'(stall), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/select_encode_sched.md
Name: select_encode_sched

Overview:
- Parametrised, registered successor to the combinational register select/encode logic in the datapath.
- Latches the instruction word and decodes the ra/rb/rc fields into one-hot register-in and register-out enables. Produces the sign-extended C constant and the opcode.
- Keeps a per-register write-pending scoreboard so the control unit can stall reads of registers that have an outstanding writeback.
- Sits between the IR and the register file / control sequencer.

Parameters:
DATA_W, 32, instruction and datapath width
NUM_REGS, 16, number of general registers; must equal 2**REG_ID_W
REG_ID_W, 4, register field width
OP_MSB, 31, opcode MSB; opcode is [OP_MSB:OP_MSB-4]
RA_MSB, 26, ra field MSB
RB_MSB, 22, rb field MSB
RC_MSB, 18, rc field MSB
IMM_W, 19, C field width, taken from [IMM_W-1:0]

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
ir_in  in  DATA_W  instruction word from memory data path
ir_load  in  1  latch ir_in into internal IR at the clock edge
gra  in  1  select ra field
grb  in  1  select rb field
grc  in  1  select rc field
rin  in  1  request register write enable
rout  in  1  request register read enable
baout  in  1  base-address read: register 0 reads as zero
wb_issue  in  1  mark the currently selected register as write-pending
wb_done  in  1  clear the pending bit of wb_done_id
wb_done_id  in  REG_ID_W  register whose writeback completed
r_in  out  NUM_REGS  one-hot register write enables
r_out  out  NUM_REGS  one-hot register read enables
ba_zero  out  1  baout read of register 0; bus must drive zero
sel_id  out  REG_ID_W  registered selected register index
opcode  out  5  opcode of latched IR
c_sign_extended  out  DATA_W  C field sign-extended from bit IMM_W-1
pending  out  NUM_REGS  scoreboard bits
stall  out  1  current read request hits a pending register

Behaviour:
- One clock domain: clk, with synchronous active-high reset clr.
- Reset: IR, r_in, r_out, ba_zero, sel_id and pending all go to 0. opcode and c_sign_extended are 0 because they derive from IR. stall is 0.
- IR: loads ir_in on the edge when ir_load=1, otherwise holds. opcode and c_sign_extended are combinational from IR, so they are valid the cycle after the load.
- Field select is combinational from IR with fixed priority gra > grb > grc. If none is asserted, the index is 0 and no enables are produced.
- Select/encode outputs are registered, one-cycle latency:
  - r_in is 1<<idx when rin and a gr* are asserted, else 0.
  - r_out is 1<<idx when (rout or baout) and a gr* are asserted, else 0.
  - With baout=1 and idx=0: r_out=0 and ba_zero=1. Otherwise ba_zero=0.
  - sel_id always updates to idx.
- At most one bit of r_in and one bit of r_out is set in any cycle.
- Loading IR in the same cycle as a select uses the old IR value for that select.
- Scoreboard, per edge:
  - wb_done clears pending[wb_done_id].
  - wb_issue sets pending[idx], where idx is the combinational select index.
  - If both target the same register, the set wins and the bit ends at 1.
  - wb_issue with no gr* asserted sets pending[0].
- stall is combinational: (rout or baout) and a gr* asserted and pending[idx]=1.
  - Exception: baout with idx=0 never stalls.
  - stall does not suppress r_out; the control unit must hold rout until stall drops.
- clr mid-operation: all pending bits are dropped and in-flight enables are cancelled on that edge.

Test Plan:
- Reset, then ir_in=0x18918000, ir_load=1 -> next cycle opcode=3, c_sign_extended=0x00018000.
- After that load, gra=grb=rin=1 -> one cycle later r_in=0x0002, r_out=0, sel_id=1. Priority check: ra wins.
- IR with C field 0x7FFFF (bit 18 set), all other fields 0 -> c_sign_extended=0xFFFFFFFF. IR with C=0x40000 -> 0xFFFC0000.
- IR with rb=0, grb=1, baout=1 -> r_out=0, ba_zero=1. Same with rb=5 -> r_out=0x0020, ba_zero=0.
- grc=1 (rc=3) with wb_issue=1 -> pending=0x0008. Then grc=1, rout=1 -> stall=1. Then wb_done=1, wb_done_id=3 -> pending=0, stall=0. Simultaneous wb_issue and wb_done on reg 3 -> pending[3]=1.
- pending=0x0008 and r_in nonzero, then clr=1 for one cycle -> all outputs 0 on the next cycle. The IR reload is required before decode resumes.
